pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter FLUSH_DEPTH, default 2, legal 1..7: consecutive cycles of squash after a redirect.
REQ-003 Parameter MC_TIMEOUT, default 64, legal ≥2: max MC_WAIT cycles before the error flag sets.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous reset, active-low.
REQ-007 pc_selection  input  2  next-PC select from EX/MEM; 2'b00 = sequential, nonzero = redirect.
REQ-008 id_rs1, id_rs2  input  REG_AW each  source registers of the instruction in ID.
REQ-009 id_uses_rs1, id_uses_rs2  input  1 each  ID instruction actually reads rs1/rs2.
REQ-010 ex_mem_read  input  1  instruction in EX is a load.
REQ-011 ex_rd  input  REG_AW  destination register of the instruction in EX.
REQ-012 mc_start  input  1  instruction in EX starts a multicycle operation (mul/div).
REQ-013 mc_done  input  1  multicycle unit result valid this cycle.
REQ-014 stall_pc  output  1  hold PC.
REQ-015 stall_ifid  output  1  hold IF/ID register.
REQ-016 stall_idex  output  1  hold ID/EX register.
REQ-017 flush_ifid  output  1  clear IF/ID register to a NOP.
REQ-018 controls_zero  output  1  zero the control signals entering ID/EX (bubble).
REQ-019 mc_timeout  output  1  sticky error: multicycle wait exceeded MC_TIMEOUT.
REQ-020 state  output  2  current FSM state, for debug.

Function
REQ-021 The FSM SHALL have states RUN, FLUSH and MC_WAIT; all stall/flush outputs SHALL be combinational from state and inputs, with zero-cycle latency.
REQ-022 The load-use condition SHALL be ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
REQ-023 In RUN with pc_selection!=0: flush_ifid=1, controls_zero=1, stalls=0; next state FLUSH with counter=FLUSH_DEPTH-1, or RUN if FLUSH_DEPTH==1.
REQ-024 In RUN with pc_selection==0 and load-use: stall_pc=1, stall_ifid=1, controls_zero=1 for exactly that cycle; state stays RUN.
REQ-025 In RUN with pc_selection==0 and mc_start=1: next state MC_WAIT, wait counter cleared; a coincident load-use SHALL still be applied that cycle.
REQ-026 Priority in RUN SHALL be redirect > load-use/mc_start; mc_start coincident with a redirect SHALL be ignored, because the younger instruction is squashed.
REQ-027 In FLUSH: flush_ifid=1 and controls_zero=1 every cycle; the counter decrements, and at counter==1 the next state is RUN.
REQ-028 In FLUSH, a new pc_selection!=0 SHALL reload the counter to FLUSH_DEPTH-1; mc_start and load-use SHALL be ignored.
REQ-029 In MC_WAIT with mc_done=0: stall_pc=stall_ifid=stall_idex=1, controls_zero=0, flush_ifid=0; the wait counter increments and saturates.
REQ-030 In MC_WAIT with mc_done=1: all outputs deasserted that same cycle; next state RUN.
REQ-031 In MC_WAIT, pc_selection SHALL be ignored, because the pipeline is frozen.
REQ-032 mc_timeout SHALL set when the wait counter reaches MC_TIMEOUT in MC_WAIT, and clear only on reset; the FSM keeps waiting for mc_done.
REQ-033 Counter widths SHALL be $clog2 of their maximum + 1, with no wrap.

Reset
REQ-034 While rst=0, state SHALL be RUN, both counters 0, mc_timeout 0, and all stall/flush outputs 0, including when reset is asserted mid-FLUSH or mid-MC_WAIT.
REQ-035 The first edge after rst deasserts SHALL evaluate normally from RUN.

Structure
REQ-036 Shared package hazard_pkg SHALL hold the state encoding (RUN=2'b00, FLUSH=2'b01, MC_WAIT=2'b10) and PC_SEL_SEQ=2'b00.
REQ-037 The REQ-022 comparator SHALL be a sub-module named load_use_detector; the FSM and counters stay in the top.

Verification
REQ-038 Load x5 in EX, ID reads rs1=x5 -> stall_pc=stall_ifid=controls_zero=1 for 1 cycle; with ex_rd=x0 -> no stall.
REQ-039 pc_selection=2'b01 for 1 cycle, FLUSH_DEPTH=2 -> flush_ifid=1 for 2 cycles, then RUN; repeat redirect in 2nd cycle -> 3 cycles total.
REQ-040 mc_start, then mc_done 5 cycles later -> stall_idex=1 for 5 cycles, 0 in the done cycle; state MC_WAIT then RUN.
REQ-041 pc_selection=2'b10 together with mc_start and load-use -> only flush/controls_zero asserted, next state FLUSH.
REQ-042 MC_TIMEOUT=4, mc_done withheld 10 cycles -> mc_timeout rises on the 4th wait cycle and stays set after mc_done.
REQ-043 rst asserted mid-MC_WAIT -> all outputs 0 asynchronously, state=RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the sequential next-PC select value.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        FLUSH   = 2'b01,
        MC_WAIT = 2'b10
    } hz_state_e;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;

    // Any non-sequential next-PC select squashes the younger instructions.
    function automatic logic is_redirect(input logic [1:0] pc_sel);
        return pc_sel != PC_SEL_SEQ;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Load-use comparator: a load in EX writes a register that the instruction
// in ID reads. Writes to x0 never create a dependency.
module load_use_detector #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    output logic              load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // Per-operand match, then qualify with the load and a non-zero target.
    always_comb begin
        rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
        load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: squashes after redirects, inserts a bubble on
// load-use, and freezes the pipeline while a multicycle unit is busy.
module pipeline_hazard_controller #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned MC_TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_selection,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mc_start,
    input  logic              mc_done,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              stall_idex,
    output logic              flush_ifid,
    output logic              controls_zero,
    output logic              mc_timeout,
    output logic [1:0]        state
);

    import hazard_pkg::*;

    localparam int unsigned FCW = $clog2(FLUSH_DEPTH + 1);
    localparam int unsigned WCW = $clog2(MC_TIMEOUT + 1);
    localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_DEPTH - 1);
    localparam logic [WCW-1:0] WAIT_MAX     = WCW'(MC_TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST    = WCW'(MC_TIMEOUT - 1);

    hz_state_e      state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           tmo_q, tmo_d;

    logic load_use;
    logic redirect;
    logic spc_c, sif_c, sie_c, flush_c, cz_c;

    load_use_detector #(
        .REG_AW (REG_AW)
    ) u_lud (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .load_use    (load_use)
    );

    assign redirect = is_redirect(pc_selection);

    // State, flush counter, wait counter and sticky timeout registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            wcnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and hazard outputs; redirect outranks load-use and mc_start.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        wcnt_d  = wcnt_q;
        tmo_d   = tmo_q;
        spc_c   = 1'b0;
        sif_c   = 1'b0;
        sie_c   = 1'b0;
        flush_c = 1'b0;
        cz_c    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    flush_c = 1'b1;
                    cz_c    = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = FLUSH_RELOAD;
                    end
                end else begin
                    if (load_use) begin
                        spc_c = 1'b1;
                        sif_c = 1'b1;
                        cz_c  = 1'b1;
                    end
                    if (mc_start) begin
                        state_d = MC_WAIT;
                        wcnt_d  = '0;
                    end
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                cz_c    = 1'b1;
                if (redirect) begin
                    fcnt_d = FLUSH_RELOAD;
                end else if (fcnt_q <= FCW'(1)) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            MC_WAIT: begin
                if (mc_done) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else begin
                    spc_c = 1'b1;
                    sif_c = 1'b1;
                    sie_c = 1'b1;
                    if (wcnt_q != WAIT_MAX) begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                    // Counter reaches MC_TIMEOUT at this edge (or already has).
                    if (wcnt_q >= WAIT_LAST) begin
                        tmo_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = '0;
                wcnt_d  = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, independent of the inputs.
    assign stall_pc      = rst & spc_c;
    assign stall_ifid    = rst & sif_c;
    assign stall_idex    = rst & sie_c;
    assign flush_ifid    = rst & flush_c;
    assign controls_zero = rst & cz_c;
    assign mc_timeout    = tmo_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (FLUSH_DEPTH=2, MC_TIMEOUT=4).
module tb_pipeline_hazard_controller;

    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_FLUSH = 2'b01;
    localparam logic [1:0] S_MCW   = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pc_selection;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, mc_start, mc_done;
    logic       stall_pc, stall_ifid, stall_idex, flush_ifid, controls_zero, mc_timeout;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    pipeline_hazard_controller #(
        .REG_AW      (5),
        .FLUSH_DEPTH (2),
        .MC_TIMEOUT  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_selection  (pc_selection),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .mc_start      (mc_start),
        .mc_done       (mc_done),
        .stall_pc      (stall_pc),
        .stall_ifid    (stall_ifid),
        .stall_idex    (stall_idex),
        .flush_ifid    (flush_ifid),
        .controls_zero (controls_zero),
        .mc_timeout    (mc_timeout),
        .state         (state)
    );

    always #5 clk = ~clk;

    // {stall_pc, stall_ifid, stall_idex, flush_ifid, controls_zero, mc_timeout, state}
    function automatic logic [7:0] ex(input logic spc, input logic sif, input logic sie,
                                      input logic fl, input logic cz, input logic tmo,
                                      input logic [1:0] st);
        return {spc, sif, sie, fl, cz, tmo, st};
    endfunction

    task automatic idle();
        pc_selection = 2'b00;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
    endtask

    task automatic load_use_x5();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        logic [7:0] obs;
        logic [7:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        obs = {stall_pc, stall_ifid, stall_idex, flush_ifid, controls_zero, mc_timeout, state};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", t, obs, e);
        end
    endtask

    // Inputs are already driven (just after negedge); check before the posedge.
    task automatic cyc(input string tag, input logic [7:0] e);
        expect_out(tag, e);
        #2;
        check_out();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(negedge clk);
        // Reset holds everything low even with hazards on the inputs.
        pc_selection = 2'b01; mc_start = 1'b1; load_use_x5();
        cyc("reset_a", ex(0,0,0,0,0,0,S_RUN));
        cyc("reset_b", ex(0,0,0,0,0,0,S_RUN));
        idle();
        rst = 1'b1;

        // Load-use on rs1 for exactly one cycle.
        load_use_x5();
        cyc("lu_rs1", ex(1,1,0,0,1,0,S_RUN));
        idle();
        cyc("lu_gone", ex(0,0,0,0,0,0,S_RUN));
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        cyc("lu_x0", ex(0,0,0,0,0,0,S_RUN));
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        cyc("lu_rs2", ex(1,1,0,0,1,0,S_RUN));
        id_uses_rs2 = 1'b0;
        cyc("lu_rs2_unused", ex(0,0,0,0,0,0,S_RUN));
        id_uses_rs2 = 1'b1; ex_mem_read = 1'b0;
        cyc("lu_not_load", ex(0,0,0,0,0,0,S_RUN));
        idle();

        // Single redirect: two flush cycles then RUN.
        pc_selection = 2'b01;
        cyc("redir_c1", ex(0,0,0,1,1,0,S_RUN));
        idle();
        cyc("redir_c2", ex(0,0,0,1,1,0,S_FLUSH));
        cyc("redir_done", ex(0,0,0,0,0,0,S_RUN));

        // Redirect repeated in the second cycle: three flush cycles.
        pc_selection = 2'b01;
        cyc("rr_c1", ex(0,0,0,1,1,0,S_RUN));
        pc_selection = 2'b11;
        cyc("rr_c2", ex(0,0,0,1,1,0,S_FLUSH));
        idle();
        cyc("rr_c3", ex(0,0,0,1,1,0,S_FLUSH));
        cyc("rr_done", ex(0,0,0,0,0,0,S_RUN));

        // FLUSH ignores load-use and mc_start.
        pc_selection = 2'b01;
        cyc("fl_ign_c1", ex(0,0,0,1,1,0,S_RUN));
        idle(); load_use_x5(); mc_start = 1'b1;
        cyc("fl_ign_c2", ex(0,0,0,1,1,0,S_FLUSH));
        idle();
        cyc("fl_ign_run", ex(0,0,0,0,0,0,S_RUN));

        // Redirect with coincident mc_start and load-use: only the flush.
        pc_selection = 2'b10; mc_start = 1'b1; load_use_x5();
        cyc("prio_c1", ex(0,0,0,1,1,0,S_RUN));
        idle();
        cyc("prio_c2", ex(0,0,0,1,1,0,S_FLUSH));
        cyc("prio_done", ex(0,0,0,0,0,0,S_RUN));

        // Multicycle op: five frozen cycles then done; timeout sets at the 4th.
        mc_start = 1'b1;
        cyc("mc_start", ex(0,0,0,0,0,0,S_RUN));
        idle();
        for (int k = 1; k <= 5; k++) begin
            pc_selection = (k == 2) ? 2'b01 : 2'b00;
            cyc($sformatf("mc_wait_%0d", k), ex(1,1,1,0,0,(k >= 5),S_MCW));
        end
        idle(); mc_done = 1'b1;
        cyc("mc_done", ex(0,0,0,0,0,1,S_MCW));
        idle();
        cyc("mc_back_run", ex(0,0,0,0,0,1,S_RUN));

        // mc_start with coincident load-use, then async reset mid-wait.
        mc_start = 1'b1; load_use_x5();
        cyc("mc_lu", ex(1,1,0,0,1,1,S_RUN));
        idle();
        cyc("mc_lu_wait", ex(1,1,1,0,0,1,S_MCW));
        expect_out("rst_async", ex(0,0,0,0,0,0,S_RUN));
        #3 rst = 1'b0;
        #1 check_out();
        @(negedge clk);
        cyc("rst_hold", ex(0,0,0,0,0,0,S_RUN));
        rst = 1'b1;
        cyc("rst_release", ex(0,0,0,0,0,0,S_RUN));

        // Timeout with mc_done withheld for ten cycles; sticky after done.
        mc_start = 1'b1;
        cyc("to_start", ex(0,0,0,0,0,0,S_RUN));
        idle();
        for (int k = 1; k <= 10; k++) begin
            cyc($sformatf("to_wait_%0d", k), ex(1,1,1,0,0,(k >= 5),S_MCW));
        end
        mc_done = 1'b1;
        cyc("to_done", ex(0,0,0,0,0,1,S_MCW));
        idle();
        cyc("to_sticky", ex(0,0,0,0,0,1,S_RUN));
        load_use_x5();
        cyc("to_lu_after", ex(1,1,0,0,1,1,S_RUN));
        idle();

        // Only reset clears the timeout flag.
        rst = 1'b0;
        cyc("to_cleared", ex(0,0,0,0,0,0,S_RUN));
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed no_finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
